// File: rtl/hazard_unit.sv
// Hazard resolver for the 5-stage F/D/E/M/W core: tracks E/M/W writers, emits D stall and forwarding selects.
// Optional stall-cycle counter output stallCnt is enabled by defining HAZARD_STAT_EN.
module hazard_unit #(
  parameter int ADDR_W = 5,
  parameter int TNEW_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rsD,
  input  logic [ADDR_W-1:0] rtD,
  input  logic              useRsD,
  input  logic              useRtD,
  input  logic [TNEW_W-1:0] tUseRsD,
  input  logic [TNEW_W-1:0] tUseRtD,
  input  logic [ADDR_W-1:0] dstD,
  input  logic              weD,
  input  logic [TNEW_W-1:0] tNewD,
  output logic              stall,
  output logic [1:0]        fwdRsD,
  output logic [1:0]        fwdRtD,
  output logic [1:0]        fwdRsE,
  output logic [1:0]        fwdRtE,
  output logic [1:0]        fwdRtM
`ifdef HAZARD_STAT_EN
  ,
  output logic [31:0]       stallCnt
`endif
);

  typedef struct packed {
    logic              valid;
    logic              we;
    logic [ADDR_W-1:0] dst;
    logic [TNEW_W-1:0] tnew;
  } rec_t;

  rec_t              e_q, m_q, w_q, e_d, m_d, w_d;
  logic [ADDR_W-1:0] rs_e_q, rt_e_q, rt_m_q, rs_e_d, rt_e_d, rt_m_d;

  // Register 0 is hardwired, so a write to it is never a dependency.
  function automatic logic writes(input rec_t r, input logic [ADDR_W-1:0] a);
    return r.valid && r.we && (r.dst == a) && (a != '0);
  endfunction

  function automatic logic src_stall(input logic used, input logic [ADDR_W-1:0] a,
                                     input logic [TNEW_W-1:0] tuse, input rec_t e, input rec_t m);
    return used && ((writes(e, a) && (e.tnew > tuse)) || (writes(m, a) && (m.tnew > tuse)));
  endfunction

  // The youngest writer decides; if its result is not ready yet the stall covers it.
  function automatic logic [1:0] pick(input rec_t r, input logic [1:0] sel);
    return (r.tnew == '0) ? sel : 2'd0;
  endfunction

  function automatic logic [1:0] fwd_from_e(input logic [ADDR_W-1:0] a, input rec_t e,
                                            input rec_t m, input rec_t w);
    if (writes(e, a))      return pick(e, 2'd1);
    else if (writes(m, a)) return pick(m, 2'd2);
    else if (writes(w, a)) return pick(w, 2'd3);
    else                   return 2'd0;
  endfunction

  function automatic logic [1:0] fwd_from_m(input logic [ADDR_W-1:0] a, input rec_t m, input rec_t w);
    if (writes(m, a))      return pick(m, 2'd2);
    else if (writes(w, a)) return pick(w, 2'd3);
    else                   return 2'd0;
  endfunction

  assign stall  = src_stall(useRsD, rsD, tUseRsD, e_q, m_q) |
                  src_stall(useRtD, rtD, tUseRtD, e_q, m_q);
  assign fwdRsD = fwd_from_e(rsD, e_q, m_q, w_q);
  assign fwdRtD = fwd_from_e(rtD, e_q, m_q, w_q);
  assign fwdRsE = fwd_from_m(rs_e_q, m_q, w_q);
  assign fwdRtE = fwd_from_m(rt_e_q, m_q, w_q);
  assign fwdRtM = writes(w_q, rt_m_q) ? pick(w_q, 2'd3) : 2'd0;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    e_d    = '0;
    rs_e_d = '0;
    rt_e_d = '0;
    if (!stall) begin
      e_d.valid = 1'b1;
      e_d.we    = weD;
      e_d.dst   = dstD;
      e_d.tnew  = tNewD;
      rs_e_d    = rsD;
      rt_e_d    = rtD;
    end
    m_d      = e_q;
    m_d.tnew = (e_q.tnew == '0) ? '0 : e_q.tnew - TNEW_W'(1);
    w_d      = m_q;
    w_d.tnew = '0;
    rt_m_d   = rt_e_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all stages update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_q    <= '0;
      m_q    <= '0;
      w_q    <= '0;
      rs_e_q <= '0;
      rt_e_q <= '0;
      rt_m_q <= '0;
    end else begin
      e_q    <= e_d;
      m_q    <= m_d;
      w_q    <= w_d;
      rs_e_q <= rs_e_d;
      rt_e_q <= rt_e_d;
      rt_m_q <= rt_m_d;
    end
  end

`ifdef HAZARD_STAT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset)      stall_cnt_q <= '0;
    else if (stall) stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign stallCnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed hazard scenarios plus random traffic against a stage-list model.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rsD, rtD, dstD;
  logic       useRsD, useRtD, weD;
  logic [1:0] tUseRsD, tUseRtD, tNewD;
  logic       stall;
  logic [1:0] fwdRsD, fwdRtD, fwdRsE, fwdRtE, fwdRtM;
`ifdef HAZARD_STAT_EN
  logic [31:0] stallCnt;
`endif

  int checks   = 0;
  int failures = 0;

  hazard_unit dut (
    .clk(clk), .reset(reset),
    .rsD(rsD), .rtD(rtD), .useRsD(useRsD), .useRtD(useRtD),
    .tUseRsD(tUseRsD), .tUseRtD(tUseRtD), .dstD(dstD), .weD(weD), .tNewD(tNewD),
    .stall(stall), .fwdRsD(fwdRsD), .fwdRtD(fwdRtD),
    .fwdRsE(fwdRsE), .fwdRtE(fwdRtE), .fwdRtM(fwdRtM)
`ifdef HAZARD_STAT_EN
    , .stallCnt(stallCnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: list of in-flight instructions, index 0=E, 1=M, 2=W.
  typedef struct {
    bit valid;
    bit we;
    int dst;
    int tnew;
  } ref_t;

  ref_t        st[3];
  int          src_e_rs, src_e_rt, src_m_rt;
  logic [31:0] exp_cnt;

  function automatic bit mwrites(int k, int r);
    return st[k].valid && st[k].we && st[k].dst == r && r != 0;
  endfunction

  function automatic bit ref_stall();
    bit s = 0;
    for (int k = 0; k < 2; k++) begin
      if (useRsD && mwrites(k, int'(rsD)) && st[k].tnew > int'(tUseRsD)) s = 1;
      if (useRtD && mwrites(k, int'(rtD)) && st[k].tnew > int'(tUseRtD)) s = 1;
    end
    return s;
  endfunction

  // Select code is stage index + 1 (E=1, M=2, W=3); youngest writer wins.
  function automatic int ref_fwd(int first, int r);
    for (int k = first; k < 3; k++)
      if (mwrites(k, r)) return (st[k].tnew == 0) ? k + 1 : 0;
    return 0;
  endfunction

  task automatic ref_clear();
    for (int k = 0; k < 3; k++) st[k] = '{0, 0, 0, 0};
    src_e_rs = 0; src_e_rt = 0; src_m_rt = 0;
    exp_cnt = '0;
  endtask

  task automatic ref_advance(input bit s);
    st[2] = st[1];
    st[2].tnew = 0;
    st[1] = st[0];
    st[1].tnew = (st[0].tnew > 0) ? st[0].tnew - 1 : 0;
    src_m_rt = src_e_rt;
    if (s) begin
      st[0] = '{0, 0, 0, 0};
      src_e_rs = 0; src_e_rt = 0;
    end else begin
      st[0] = '{1, weD, int'(dstD), int'(tNewD)};
      src_e_rs = int'(rsD); src_e_rt = int'(rtD);
    end
    if (s) exp_cnt = exp_cnt + 32'd1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_d(input int rs, input int rt, input bit urs, input bit urt,
                       input int tus, input int tut, input int dst, input bit we, input int tn);
    rsD = 5'(rs); rtD = 5'(rt); useRsD = urs; useRtD = urt;
    tUseRsD = 2'(tus); tUseRtD = 2'(tut); dstD = 5'(dst); weD = we; tNewD = 2'(tn);
  endtask

  task automatic set_idle();
    set_d(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Compare every output against the model; inputs were applied one time unit earlier.
  task automatic check_model(input string tag);
    #1;
    chk({tag, ".stall"},  32'(stall),  32'(ref_stall()));
    chk({tag, ".fwdRsD"}, 32'(fwdRsD), 32'(ref_fwd(0, int'(rsD))));
    chk({tag, ".fwdRtD"}, 32'(fwdRtD), 32'(ref_fwd(0, int'(rtD))));
    chk({tag, ".fwdRsE"}, 32'(fwdRsE), 32'(ref_fwd(1, src_e_rs)));
    chk({tag, ".fwdRtE"}, 32'(fwdRtE), 32'(ref_fwd(1, src_e_rt)));
    chk({tag, ".fwdRtM"}, 32'(fwdRtM), 32'(ref_fwd(2, src_m_rt)));
`ifdef HAZARD_STAT_EN
    chk({tag, ".stallCnt"}, stallCnt, exp_cnt);
`endif
  endtask

  task automatic tick();
    bit s;
    s = ref_stall();
    @(posedge clk);
    #1;
    if (reset) ref_clear();
    else       ref_advance(s);
  endtask

  task automatic step(input string tag);
    check_model(tag);
    tick();
  endtask

  task automatic flush();
    set_idle();
    for (int i = 0; i < 3; i++) step("flush");
  endtask

  initial begin
    bit hold;
    reset = 1'b1;
    set_idle();
    ref_clear();
    @(posedge clk); #1;
    @(posedge clk); #1;
    ref_clear();
    reset = 1'b0;

    // Reset state
    check_model("reset");
    chk("reset.stall_zero", 32'(stall), 32'd0);
    chk("reset.fwd_zero", 32'({fwdRsD, fwdRtD, fwdRsE, fwdRtE, fwdRtM}), 32'd0);
    tick();

    // lw $1 -> add rs=$1: one stall, then W forward into E
    set_d(5, 0, 1, 0, 1, 0, 1, 1, 2);           step("lw1");
    set_d(1, 2, 1, 1, 1, 1, 4, 1, 1);           check_model("add_lwE");
    chk("lw_add.stall_lwE", 32'(stall), 32'd1); tick();
    check_model("add_lwM");
    chk("lw_add.stall_lwM", 32'(stall), 32'd0); tick();
    set_idle();                                 check_model("add_inE");
    chk("lw_add.fwdRsE_W", 32'(fwdRsE), 32'd3); tick();
    flush();

    // add $2 -> beq rs=$2 (Tuse 0): one stall, then M forward into D
    set_d(3, 4, 1, 1, 1, 1, 2, 1, 1);           step("add2");
    set_d(2, 6, 1, 1, 0, 0, 0, 0, 0);           check_model("beq_addE");
    chk("add_beq.stall", 32'(stall), 32'd1);    tick();
    check_model("beq_addM");
    chk("add_beq.stall_clr", 32'(stall), 32'd0);
    chk("add_beq.fwdRsD_M", 32'(fwdRsD), 32'd2); tick();
    flush();

    // jal -> jr $31: E forward into D, no stall
    set_d(0, 0, 0, 0, 0, 0, 31, 1, 0);          step("jal");
    set_d(31, 0, 1, 0, 0, 0, 0, 0, 0);          check_model("jr");
    chk("jal_jr.stall", 32'(stall), 32'd0);
    chk("jal_jr.fwdRsD_E", 32'(fwdRsD), 32'd1); tick();
    flush();

    // lw $3 -> sw rt=$3 (Tuse 2): no stall, store data forwarded from W into M
    set_d(8, 0, 1, 0, 1, 0, 3, 1, 2);           step("lw3");
    set_d(7, 3, 1, 1, 1, 2, 0, 0, 0);           check_model("sw_D");
    chk("lw_sw.stall", 32'(stall), 32'd0);      tick();
    set_idle();                                 check_model("sw_E");
    chk("lw_sw.fwdRtE", 32'(fwdRtE), 32'd0);    tick();
    check_model("sw_M");
    chk("lw_sw.fwdRtM_W", 32'(fwdRtM), 32'd3);  tick();
    flush();

    // Writes to $0 never match
    set_d(9, 0, 1, 0, 1, 0, 0, 1, 1);           step("ori0");
    set_d(0, 0, 1, 1, 0, 0, 5, 1, 1);
    for (int i = 0; i < 3; i++) begin
      check_model("add0");
      chk("r0.all_zero", 32'({stall, fwdRsD, fwdRtD, fwdRsE, fwdRtE, fwdRtM}), 32'd0);
      tick();
    end
    flush();

    // rs==rt: identical selects
    set_d(0, 0, 0, 0, 0, 0, 6, 1, 0);           step("li6");
    set_d(6, 6, 1, 1, 1, 1, 0, 0, 0);           check_model("rs_eq_rt");
    chk("rs_eq_rt.same", 32'(fwdRsD), 32'(fwdRtD)); tick();
    flush();

    // Pending stall cleared by a one-cycle reset
    set_d(5, 0, 1, 0, 1, 0, 1, 1, 2);           step("lw_rst");
    set_d(1, 0, 1, 0, 1, 0, 4, 1, 1);           check_model("add_rst");
    chk("rst.pending_stall", 32'(stall), 32'd1);
    reset = 1'b1;                               tick();
    reset = 1'b0;                               check_model("post_rst");
    chk("rst.stall_zero", 32'(stall), 32'd0);
    chk("rst.fwd_zero", 32'({fwdRsD, fwdRtD, fwdRsE, fwdRtE, fwdRtM}), 32'd0);
`ifdef HAZARD_STAT_EN
    chk("rst.stallCnt_zero", stallCnt, 32'd0);
`endif
    tick();

    // Random traffic; D is held while the model says stall, as the real pipeline would
    hold = 0;
    for (int i = 0; i < 500; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      if (!hold)
        set_d($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), $urandom_range(0, 1), $urandom_range(0, 2),
              $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
      check_model("rand");
      hold = ref_stall() && !reset;
      tick();
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline hazard resolver for the 5-stage MIPS core (F/D/E/M/W).
- Consumes the per-instruction Tuse/Tnew/destination information produced by the D-stage decoder.
- Tracks in-flight writers in E, M and W internally, and emits the D-stage stall and all forwarding-mux selects.
- Sits beside the pipeline registers; its stall output drives the F/D hold and the E-stage bubble.

Parameters:
- ADDR_W, 5, register address width.
- TNEW_W, 2, Tnew/Tuse field width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- rsD  in  ADDR_W  rs field of the instruction in D
- rtD  in  ADDR_W  rt field of the instruction in D
- useRsD  in  1  instruction in D reads rs
- useRtD  in  1  instruction in D reads rt
- tUseRsD  in  TNEW_W  Tuse of rs (0 or 1)
- tUseRtD  in  TNEW_W  Tuse of rt (0..2)
- dstD  in  ADDR_W  resolved destination register (after regDst mux)
- weD  in  1  instruction in D writes the GPR file
- tNewD  in  TNEW_W  Tnew as seen on entry to E
- stall  out  1  hold PC and F/D; insert bubble into E
- fwdRsD  out  2  D-stage rs select: 0 GRF, 1 E, 2 M, 3 W
- fwdRtD  out  2  D-stage rt select, same encoding
- fwdRsE  out  2  E-stage rs select: 0 pipe reg, 2 M, 3 W
- fwdRtE  out  2  E-stage rt select, same encoding
- fwdRtM  out  2  M-stage rt (store data) select: 0 pipe reg, 3 W

Behaviour:
- State:
  - One record per stage for E, M, W: {valid, we, dst, tNew}.
  - Latched source fields: rsE, rtE, rtM.
- Reset: all records cleared (valid=0, dst=0, tNew=0); rsE=rtE=rtM=0. Therefore stall=0 and all fwd*=0 in the cycle after reset.
- Reset is synchronous and overrides stall and normal advance.
- Per-cycle advance, no stall:
  - E <= D fields; E.tNew = tNewD.
  - M <= E with tNew = (E.tNew==0 ? 0 : E.tNew-1).
  - W <= M with tNew = 0.
  - rsE/rtE <= rsD/rtD; rtM <= rtE.
- Per-cycle advance, stall:
  - E <= bubble (valid=0, we=0, dst=0); rsE=rtE=0.
  - M and W advance exactly as in the no-stall case.
- A stage "writes r" iff valid & we & dst==r & r!=0. Register 0 never matches.
- stall (combinational):
  - For each used source s in D with Tuse u, stall=1 if E writes s with E.tNew>u, or M writes s with M.tNew>u.
  - W never stalls.
- Forward selection (combinational), youngest matching stage first:
  - fwd*D checks E, then M, then W.
  - fwd*E checks M, then W.
  - fwdRtM checks W only.
  - The first stage that writes the register supplies it only if its tNew==0; otherwise the select is 0, because stall covers that case.
  - Older stages are never consulted past the youngest match.
- Boundaries:
  - A bubble never matches anything.
  - tNew saturates at 0 and never wraps.
  - A simultaneous rs/rt dependency on different stages stalls if either term requires it.
  - rs==rt gives identical selects for both.
- Latency: stall and fwd* are same-cycle functions of the registered state and the D inputs. State updates on the clk edge.

Optional Feature:
- Macro HAZARD_STAT_EN.
- Defined:
  - Adds output stallCnt, 32 bits.
  - Counts cycles with stall=1.
  - Cleared by reset.
  - Wraps from 0xFFFFFFFF to 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- lw $1 (weD=1, dstD=1, tNewD=2) followed by add rs=$1 (tUseRs=1):
  - Cycle with lw in E: stall=1.
  - Next cycle (lw in M, tNew=1): stall=0.
  - Following cycle: fwdRsE=3 (W).
- add $2 (tNewD=1) followed by beq rs=$2 (tUseRs=0):
  - One stall cycle.
  - Then add in M with tNew=0 gives fwdRsD=2, stall=0.
- jal (dstD=31, tNewD=0) followed by jr rs=$31 (tUseRs=0): stall=0, fwdRsD=1 (E) in the same cycle.
- lw $3 followed by sw rt=$3 (tUseRt=2):
  - No stall.
  - With sw in E: fwdRtE=0.
  - With sw in M (lw in W): fwdRtM=3.
- ori $0 (dstD=0, weD=1) followed by add rs=$0, rt=$0: stall=0; all fwd*=0 throughout.
- Pending stall from lw→add, then reset asserted for 1 cycle:
  - Next cycle: stall=0, all fwd*=0, all records invalid.
  - With HAZARD_STAT_EN: stallCnt=0.
